// File: rtl/tt_checkpoint_stack.sv
// -----------------------------------------------------------------------------
// tt_checkpoint_stack
//
// Purpose:
//   Keeps snapshots of the register translation table, one per renamed branch,
//   in program order. A correct resolve releases the oldest snapshot. A
//   mispredict sends the oldest snapshot back to the translation table as a
//   one-cycle restore pulse and empties the stack.
//
// Ports:
//   clk                 clock
//   n_rst               synchronous active-low reset
//   save                branch renamed this cycle; capture the current table
//   d_translation_in    16 x D_W data-register mappings, logical reg i at [i*D_W +: D_W]
//   s_translation_in    status-register mapping
//   resolve_valid       oldest outstanding branch resolved this cycle
//   resolve_mispredict  qualifies resolve_valid; 1 = mispredicted
//   restore             one-cycle restore pulse to the translation table
//   d_translation       restored data mappings, valid while restore=1
//   s_translation       restored status mapping, valid while restore=1
//   full / empty        count == DEPTH / count == 0
//   count               number of live snapshots
// -----------------------------------------------------------------------------
`ifndef NUM_D_REG
`define NUM_D_REG 64
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 16
`endif

module tt_checkpoint_stack #(
  parameter int DEPTH = 4,
  parameter int D_W   = $clog2(`NUM_D_REG),
  parameter int S_W   = $clog2(`NUM_S_REG),
  // Set to 0 by environments that deliberately exercise an empty mispredict.
  parameter bit CHECK_EMPTY_MISPREDICT = 1'b1,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int D_ALL_W = 16 * D_W,
  localparam int ENTRY_W = D_ALL_W + S_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               save,
  input  logic [D_ALL_W-1:0] d_translation_in,
  input  logic [S_W-1:0]     s_translation_in,
  input  logic               resolve_valid,
  input  logic               resolve_mispredict,
  output logic               restore,
  output logic [D_ALL_W-1:0] d_translation,
  output logic [S_W-1:0]     s_translation,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  // Snapshot storage: {status mapping, data mappings}. No reset needed.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               restore_q, restore_d;
  logic [D_ALL_W-1:0] d_out_q, d_out_d;
  logic [S_W-1:0]     s_out_q, s_out_d;

  logic full_w, empty_w;
  logic correct_ok, mispredict_ok, save_ok;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // During the restore cycle the stack is already empty and the front end is
  // flushing, so resolves and saves are both ignored there.
  assign correct_ok    = resolve_valid && !resolve_mispredict && !empty_w && !restore_q;
  assign mispredict_ok = resolve_valid &&  resolve_mispredict && !empty_w && !restore_q;
  // A save alongside a mispredict belongs to the wrong path and is dropped.
  // When full, a same-cycle correct resolve frees the head slot, which is
  // exactly where tail points, so the new snapshot can take it.
  assign save_ok = save && !restore_q && !mispredict_ok && (!full_w || correct_ok);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    restore_d = 1'b0;
    d_out_d   = d_out_q;
    s_out_d   = s_out_q;
    if (mispredict_ok) begin
      restore_d = 1'b1;
      d_out_d   = mem_q[head_q][D_ALL_W-1:0];
      s_out_d   = mem_q[head_q][ENTRY_W-1 -: S_W];
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end else begin
      if (save_ok)    tail_d = tail_q + PTR_W'(1);
      if (correct_ok) head_d = head_q + PTR_W'(1);
      if (save_ok && !correct_ok)      count_d = count_q + CNT_W'(1);
      else if (!save_ok && correct_ok) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      restore_q <= 1'b0;
      d_out_q   <= '0;
      s_out_q   <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      restore_q <= restore_d;
      d_out_q   <= d_out_d;
      s_out_q   <= s_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst && save_ok) begin
      mem_q[tail_q] <= {s_translation_in, d_translation_in};
    end
  end

  assign restore       = restore_q;
  assign d_translation = d_out_q;
  assign s_translation = s_out_q;
  assign full          = full_w;
  assign empty         = empty_w;
  assign count         = count_q;

  // A mispredict with nothing outstanding means upstream lost track of a branch.
  if (CHECK_EMPTY_MISPREDICT) begin : g_chk_empty_mispredict
    a_no_empty_mispredict : assert property (@(posedge clk) disable iff (!n_rst)
      !(resolve_valid && resolve_mispredict && !restore_q && empty_w));
  end

endmodule

// File: tb/tb_tt_checkpoint_stack.sv
// -----------------------------------------------------------------------------
// tb_tt_checkpoint_stack
//
// Purpose:
//   Directed scoreboard bench for tt_checkpoint_stack (DEPTH=4). Each stimulus
//   step drives one cycle of inputs and queues the hand-computed outputs
//   expected after that edge; an independent monitor pops one entry per cycle
//   and compares restore, count, full, empty and the restored mappings.
//   Each snapshot is tagged by a value v: logical regs 0 and 3 map to v,
//   every other reg i maps to v+i, the status mapping is v^0xA.
// -----------------------------------------------------------------------------
module tb_tt_checkpoint_stack;

  localparam int DEPTH = 4;
  localparam int DW    = 6;
  localparam int SW    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              n_rst;
  logic              save;
  logic [16*DW-1:0]  d_translation_in;
  logic [SW-1:0]     s_translation_in;
  logic              resolve_valid;
  logic              resolve_mispredict;
  logic              restore;
  logic [16*DW-1:0]  d_translation;
  logic [SW-1:0]     s_translation;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;

  tt_checkpoint_stack #(
    .DEPTH(DEPTH), .D_W(DW), .S_W(SW), .CHECK_EMPTY_MISPREDICT(1'b0)
  ) dut (
    .clk(clk), .n_rst(n_rst), .save(save),
    .d_translation_in(d_translation_in), .s_translation_in(s_translation_in),
    .resolve_valid(resolve_valid), .resolve_mispredict(resolve_mispredict),
    .restore(restore), .d_translation(d_translation), .s_translation(s_translation),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       erst;
    logic [2:0] ecnt;
    logic [7:0] ev;
    logic       ezero;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [16*DW-1:0] mk_d(input logic [7:0] v);
    logic [16*DW-1:0] r;
    for (int i = 0; i < 16; i++)
      r[i*DW +: DW] = (i == 0 || i == 3) ? DW'(v) : DW'(v + 8'(i));
    return r;
  endfunction

  function automatic logic [SW-1:0] mk_s(input logic [7:0] v);
    return SW'(v ^ 8'h0A);
  endfunction

  task automatic chk(input string nm, input string what,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, what, act, exp);
    end
  endtask

  // One cycle of stimulus plus the expected outputs after the coming edge.
  task automatic step(input string nm, input bit rst_n, input bit sv, input logic [7:0] v,
                      input bit rv, input bit rm, input int ecnt, input bit erst,
                      input logic [7:0] ev, input bit ezero);
    exp_t e;
    @(negedge clk);
    n_rst              = rst_n;
    save               = sv;
    d_translation_in   = mk_d(v);
    s_translation_in   = mk_s(v);
    resolve_valid      = rv;
    resolve_mispredict = rm;
    e.erst  = erst;
    e.ecnt  = 3'(ecnt);
    e.ev    = ev;
    e.ezero = ezero;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Monitor: one expectation per cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        chk(nm, "restore", 128'(restore), 128'(e.erst));
        chk(nm, "count",   128'(count),   128'(e.ecnt));
        chk(nm, "full",    128'(full),    128'(e.ecnt == 3'd4));
        chk(nm, "empty",   128'(empty),   128'(e.ecnt == 3'd0));
        if (e.erst) begin
          chk(nm, "d_translation", 128'(d_translation), 128'(mk_d(e.ev)));
          chk(nm, "s_translation", 128'(s_translation), 128'(mk_s(e.ev)));
        end
        if (e.ezero) begin
          chk(nm, "d_zero", 128'(d_translation), 128'(0));
          chk(nm, "s_zero", 128'(s_translation), 128'(0));
        end
      end
    end
  end

  initial begin
    n_rst = 1'b0; save = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    d_translation_in = '0; s_translation_in = '0;

    //   name          rst sv  v    rv rm cnt rs ev  zero
    step("reset0",      0, 0,  0,   0, 0, 0,  0, 0,  1);
    step("reset1",      0, 0,  0,   0, 0, 0,  0, 0,  1);
    step("idle",        1, 0,  0,   0, 0, 0,  0, 0,  1);

    // Fill and drop
    step("fill1",       1, 1,  1,   0, 0, 1,  0, 0,  0);
    step("fill2",       1, 1,  2,   0, 0, 2,  0, 0,  0);
    step("fill3",       1, 1,  3,   0, 0, 3,  0, 0,  0);
    step("fill4",       1, 1,  4,   0, 0, 4,  0, 0,  0);
    step("fill5drop",   1, 1,  5,   0, 0, 4,  0, 0,  0);
    step("drain1",      1, 0,  0,   1, 0, 3,  0, 0,  0);
    step("drain2",      1, 0,  0,   1, 0, 2,  0, 0,  0);
    step("drain3",      1, 0,  0,   1, 0, 1,  0, 0,  0);
    step("drain4",      1, 0,  0,   1, 0, 0,  0, 0,  0);
    step("rslv_empty",  1, 0,  0,   1, 0, 0,  0, 0,  0);
    step("mp_empty",    1, 0,  0,   1, 1, 0,  0, 0,  0);
    step("mp_empty_nx", 1, 0,  0,   0, 0, 0,  0, 0,  0);

    // Mispredict restore returns the oldest snapshot
    step("mp_save7",    1, 1,  7,   0, 0, 1,  0, 0,  0);
    step("mp_save9",    1, 1,  9,   0, 0, 2,  0, 0,  0);
    step("mp_restore",  1, 0,  0,   1, 1, 0,  1, 7,  0);
    step("mp_after",    1, 0,  0,   0, 0, 0,  0, 0,  0);

    // Wrap-around: D lands in the last slot, E and F wrap
    step("wr_A",        1, 1, 10,   0, 0, 1,  0, 0,  0);
    step("wr_B",        1, 1, 11,   0, 0, 2,  0, 0,  0);
    step("wr_C",        1, 1, 12,   0, 0, 3,  0, 0,  0);
    step("wr_rA",       1, 0,  0,   1, 0, 2,  0, 0,  0);
    step("wr_rB",       1, 0,  0,   1, 0, 1,  0, 0,  0);
    step("wr_D",        1, 1, 13,   0, 0, 2,  0, 0,  0);
    step("wr_E",        1, 1, 14,   0, 0, 3,  0, 0,  0);
    step("wr_F",        1, 1, 15,   0, 0, 4,  0, 0,  0);
    step("wr_rC",       1, 0,  0,   1, 0, 3,  0, 0,  0);
    step("wr_mp",       1, 0,  0,   1, 1, 0,  1, 13, 0);
    step("wr_after",    1, 0,  0,   0, 0, 0,  0, 0,  0);

    // Full + save + correct resolve: new snapshot takes the old head slot
    step("fs_20",       1, 1, 20,   0, 0, 1,  0, 0,  0);
    step("fs_21",       1, 1, 21,   0, 0, 2,  0, 0,  0);
    step("fs_22",       1, 1, 22,   0, 0, 3,  0, 0,  0);
    step("fs_23",       1, 1, 23,   0, 0, 4,  0, 0,  0);
    step("fs_sv_rs",    1, 1, 24,   1, 0, 4,  0, 0,  0);
    step("fs_r1",       1, 0,  0,   1, 0, 3,  0, 0,  0);
    step("fs_r2",       1, 0,  0,   1, 0, 2,  0, 0,  0);
    step("fs_r3",       1, 0,  0,   1, 0, 1,  0, 0,  0);
    step("fs_mp",       1, 0,  0,   1, 1, 0,  1, 24, 0);
    step("fs_after",    1, 0,  0,   0, 0, 0,  0, 0,  0);

    // Save in the mispredict cycle and in the restore cycle are both dropped
    step("sm_30",       1, 1, 30,   0, 0, 1,  0, 0,  0);
    step("sm_mp_sv31",  1, 1, 31,   1, 1, 0,  1, 30, 0);
    step("sm_rc_sv32",  1, 1, 32,   1, 0, 0,  0, 0,  0);
    step("sm_idle",     1, 0,  0,   0, 0, 0,  0, 0,  0);
    step("sm_33",       1, 1, 33,   0, 0, 1,  0, 0,  0);
    step("sm_mp33",     1, 0,  0,   1, 1, 0,  1, 33, 0);
    step("sm_after",    1, 0,  0,   0, 0, 0,  0, 0,  0);

    // Reset during the restore cycle, and reset overriding a pending mispredict
    step("rr_40",       1, 1, 40,   0, 0, 1,  0, 0,  0);
    step("rr_mp",       1, 0,  0,   1, 1, 0,  1, 40, 0);
    step("rr_rst",      0, 0,  0,   0, 0, 0,  0, 0,  1);
    step("rr_41",       1, 1, 41,   0, 0, 1,  0, 0,  0);
    step("rr_mp_rst",   0, 0,  0,   1, 1, 0,  0, 0,  1);
    step("rr_after",    1, 0,  0,   0, 0, 0,  0, 0,  1);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
